// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - in-order issue control: scoreboard, RAW/branch/memory stalls (optional ISSUE_WB_BYPASS_EN)
module issue_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [6:0]             id_opcode,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic [4:0]             id_rd,
    input  logic                   br_resolve,
    input  logic                   br_taken,
    input  logic                   mem_ready,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_addr,
    output logic                   issue,
    output logic                   stall,
    output logic                   bubble,
    output logic                   flush,
    output logic [31:0]            busy_vec,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic [1:0]             state
);

    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_BR_WAIT  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            busy_vec_q, busy_vec_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic        rs1_used, rs2_used, is_writer, is_branch, is_mem;
    logic        hazard;
    logic [31:0] wb_mask, set_mask, busy_eff;

    // Opcode decode: which sources are read, and whether rd is written
    always_comb begin
        rs1_used  = (id_opcode == OP_ALUI) || (id_opcode == OP_LOAD) || (id_opcode == OP_STORE) ||
                    (id_opcode == OP_ALU)  || (id_opcode == OP_BR);
        rs2_used  = (id_opcode == OP_STORE) || (id_opcode == OP_ALU) || (id_opcode == OP_BR);
        is_writer = ((id_opcode == OP_ALUI) || (id_opcode == OP_LOAD) || (id_opcode == OP_ALU)) &&
                    (id_rd != 5'd0);
        is_branch = (id_opcode == OP_BR);
        is_mem    = (id_opcode == OP_LOAD) || (id_opcode == OP_STORE);
    end

    // Hazard check against the scoreboard; the bypass build lets a same-cycle writeback satisfy it
    always_comb begin
        wb_mask = (wb_valid && (wb_addr != 5'd0)) ? (32'd1 << wb_addr) : 32'd0;
`ifdef ISSUE_WB_BYPASS_EN
        busy_eff = busy_vec_q & ~wb_mask;
`else
        busy_eff = busy_vec_q;
`endif
        hazard = (rs1_used && (id_rs1 != 5'd0) && busy_eff[id_rs1]) ||
                 (rs2_used && (id_rs2 != 5'd0) && busy_eff[id_rs2]);
    end

    // Next-state and pipeline-control outputs
    always_comb begin
        issue   = 1'b0;
        stall   = 1'b0;
        bubble  = 1'b0;
        flush   = 1'b0;
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (!id_valid) begin
                    bubble = 1'b1;
                end else if (hazard) begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end else begin
                    issue = 1'b1;
                    if (is_branch)   state_d = ST_BR_WAIT;
                    else if (is_mem) state_d = ST_MEM_WAIT;
                end
            end
            ST_BR_WAIT: begin
                stall  = 1'b1;
                bubble = 1'b1;
                if (br_resolve) begin
                    flush   = br_taken;
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                stall  = 1'b1;
                bubble = 1'b1;
                if (mem_ready) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Scoreboard and stall counter next values; a set wins over a same-register clear
    always_comb begin
        set_mask      = (issue && is_writer) ? (32'd1 << id_rd) : 32'd0;
        busy_vec_d    = (busy_vec_q & ~wb_mask) | set_mask;
        busy_vec_d[0] = 1'b0;
        stall_cnt_d   = stall_cnt_q;
        if (stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            busy_vec_q  <= 32'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_vec_q  <= busy_vec_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign busy_vec  = busy_vec_q;
    assign stall_cnt = stall_cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - directed self-checking bench for issue_ctrl
module tb_issue_ctrl;

    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        br_resolve, br_taken, mem_ready, wb_valid;
    logic [4:0]  wb_addr;
    logic        issue, stall, bubble, flush;
    logic [31:0] busy_vec;
    logic [15:0] stall_cnt;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;

    issue_ctrl #(.STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .br_resolve(br_resolve), .br_taken(br_taken), .mem_ready(mem_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr),
        .issue(issue), .stall(stall), .bubble(bubble), .flush(flush),
        .busy_vec(busy_vec), .stall_cnt(stall_cnt), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [6:0] op, input logic [4:0] r1,
                            input logic [4:0] r2, input logic [4:0] rd);
        id_valid  = v;
        id_opcode = op;
        id_rs1    = r1;
        id_rs2    = r2;
        id_rd     = rd;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        br_resolve = 1'b0; br_taken = 1'b0; mem_ready = 1'b0;
        wb_valid = 1'b0; wb_addr = 5'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (state !== 2'd0)      begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
        total++; if (busy_vec !== 32'd0)  begin bad++; $display("FAIL rst_busy got=%h exp=0", busy_vec); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", stall_cnt); end
        total++; if ({issue, stall, bubble, flush} !== 4'b0010)
            begin bad++; $display("FAIL rst_idle_ctl got=%b exp=0010", {issue, stall, bubble, flush}); end
        // get into MEM_WAIT with a pending write and some stall cycles, then reset mid-wait
        drive_id(1'b1, OP_LOAD, 5'd0, 5'd0, 5'd7);
        tick();
        drive_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        @(negedge clk);
        total++; if (state !== 2'd2) begin bad++; $display("FAIL rst_pre_state got=%0d exp=2", state); end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++; if (state !== 2'd0)      begin bad++; $display("FAIL rst_mid_state got=%0d exp=0", state); end
        total++; if (busy_vec !== 32'd0)  begin bad++; $display("FAIL rst_mid_busy got=%h exp=0", busy_vec); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_mid_cnt got=%0d exp=0", stall_cnt); end
        total++; if ({issue, bubble, stall} !== 3'b010)
            begin bad++; $display("FAIL rst_mid_ctl got=%b exp=010", {issue, bubble, stall}); end
    endtask

    task automatic test_raw();
        do_reset();
        drive_id(1'b1, OP_ALU, 5'd1, 5'd2, 5'd5);
        @(negedge clk);
        total++; if (issue !== 1'b1) begin bad++; $display("FAIL raw_c0_issue got=%b exp=1", issue); end
        tick();
        for (int c = 1; c <= 3; c++) begin
            drive_id(1'b1, OP_ALUI, 5'd5, 5'd0, 5'd6);
            @(negedge clk);
            total++; if ({issue, stall, bubble} !== 3'b011)
                begin bad++; $display("FAIL raw_c%0d_ctl got=%b exp=011", c, {issue, stall, bubble}); end
            total++; if (busy_vec !== 32'h20)
                begin bad++; $display("FAIL raw_c%0d_busy got=%h exp=00000020", c, busy_vec); end
            tick();
        end
        wb_valid = 1'b1; wb_addr = 5'd5;
        @(negedge clk);
`ifdef ISSUE_WB_BYPASS_EN
        total++; if ({issue, stall} !== 2'b10) begin bad++; $display("FAIL raw_c4_ctl got=%b exp=10", {issue, stall}); end
`else
        total++; if ({issue, stall} !== 2'b01) begin bad++; $display("FAIL raw_c4_ctl got=%b exp=01", {issue, stall}); end
`endif
        tick();
        wb_valid = 1'b0; wb_addr = 5'd0;
        @(negedge clk);
        total++; if (issue !== 1'b1) begin bad++; $display("FAIL raw_c5_issue got=%b exp=1", issue); end
        total++; if (busy_vec[5] !== 1'b0) begin bad++; $display("FAIL raw_c5_busy5 got=%b exp=0", busy_vec[5]); end
        tick();
        // r6 now pending: rs2 use of it stalls, an opcode that reads no sources does not
        drive_id(1'b1, OP_ALU, 5'd0, 5'd6, 5'd8);
        @(negedge clk);
        total++; if ({issue, stall} !== 2'b01) begin bad++; $display("FAIL raw_rs2_ctl got=%b exp=01", {issue, stall}); end
        tick();
        drive_id(1'b1, OP_LUI, 5'd6, 5'd6, 5'd9);
        @(negedge clk);
        total++; if ({issue, stall} !== 2'b10) begin bad++; $display("FAIL raw_lui_ctl got=%b exp=10", {issue, stall}); end
        tick();
        drive_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        total++; if (busy_vec !== 32'h40) begin bad++; $display("FAIL raw_lui_busy got=%h exp=00000040", busy_vec); end
    endtask

    task automatic test_branch();
        do_reset();
        drive_id(1'b1, OP_BR, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        total++; if ({issue, state} !== 3'b100) begin bad++; $display("FAIL br_issue got=%b exp=100", {issue, state}); end
        tick();
        drive_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin br_resolve = 1'b1; br_taken = 1'b1; end
            @(negedge clk);
            total++; if (state !== 2'd1) begin bad++; $display("FAIL br_c%0d_state got=%0d exp=1", c, state); end
            total++; if ({stall, bubble, flush} !== ((c == 3) ? 3'b111 : 3'b110))
                begin bad++; $display("FAIL br_c%0d_ctl got=%b exp=%b", c, {stall, bubble, flush}, (c == 3) ? 3'b111 : 3'b110); end
            tick();
        end
        br_resolve = 1'b0; br_taken = 1'b0;
        @(negedge clk);
        total++; if ({state, flush, stall} !== 4'b0000) begin bad++; $display("FAIL br_after got=%b exp=0000", {state, flush, stall}); end
        total++; if (stall_cnt !== 16'd3) begin bad++; $display("FAIL br_cnt got=%0d exp=3", stall_cnt); end
        // not-taken branch resolving in its first wait cycle: no flush
        drive_id(1'b1, OP_BR, 5'd0, 5'd0, 5'd0);
        tick();
        drive_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        br_resolve = 1'b1; br_taken = 1'b0;
        @(negedge clk);
        total++; if ({stall, flush} !== 2'b10) begin bad++; $display("FAIL br_nt_ctl got=%b exp=10", {stall, flush}); end
        tick();
        br_resolve = 1'b0;
        @(negedge clk);
        total++; if (state !== 2'd0)      begin bad++; $display("FAIL br_nt_state got=%0d exp=0", state); end
        total++; if (stall_cnt !== 16'd4) begin bad++; $display("FAIL br_nt_cnt got=%0d exp=4", stall_cnt); end
    endtask

    task automatic test_load();
        do_reset();
        drive_id(1'b1, OP_ALUI, 5'd0, 5'd0, 5'd3);
        tick();
        drive_id(1'b1, OP_LOAD, 5'd0, 5'd0, 5'd7);
        @(negedge clk);
        total++; if (issue !== 1'b1) begin bad++; $display("FAIL ld_issue got=%b exp=1", issue); end
        tick();
        drive_id(1'b1, OP_ALU, 5'd1, 5'd2, 5'd4);
        for (int c = 1; c <= 4; c++) begin
            wb_valid = (c == 2); wb_addr = (c == 2) ? 5'd3 : 5'd0;
            mem_ready = (c == 4);
            @(negedge clk);
            total++; if ({state, stall, issue} !== 4'b1010)
                begin bad++; $display("FAIL ld_c%0d_ctl got=%b exp=1010", c, {state, stall, issue}); end
            total++; if (busy_vec[7] !== 1'b1) begin bad++; $display("FAIL ld_c%0d_busy7 got=%b exp=1", c, busy_vec[7]); end
            tick();
        end
        mem_ready = 1'b0; wb_valid = 1'b0; wb_addr = 5'd0;
        drive_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        total++; if ({state, stall} !== 3'b000) begin bad++; $display("FAIL ld_after got=%b exp=000", {state, stall}); end
        total++; if (busy_vec !== 32'h80)  begin bad++; $display("FAIL ld_busy got=%h exp=00000080", busy_vec); end
        total++; if (stall_cnt !== 16'd4)  begin bad++; $display("FAIL ld_cnt got=%0d exp=4", stall_cnt); end
    endtask

    task automatic test_writeback();
        do_reset();
        drive_id(1'b1, OP_ALUI, 5'd0, 5'd0, 5'd0);
        tick();
        drive_id(1'b1, OP_ALUI, 5'd0, 5'd0, 5'd9);
        wb_valid = 1'b1; wb_addr = 5'd9;
        @(negedge clk);
        total++; if (busy_vec !== 32'd0) begin bad++; $display("FAIL wb_rd0_busy got=%h exp=0", busy_vec); end
        tick();
        drive_id(1'b1, OP_STORE, 5'd0, 5'd0, 5'd4);
        wb_valid = 1'b1; wb_addr = 5'd0;
        @(negedge clk);
        total++; if (busy_vec !== 32'h200) begin bad++; $display("FAIL wb_setclr_busy got=%h exp=00000200", busy_vec); end
        tick();
        drive_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        wb_valid = 1'b0;
        @(negedge clk);
        total++; if (busy_vec !== 32'h200) begin bad++; $display("FAIL wb_store_busy got=%h exp=00000200", busy_vec); end
        total++; if (state !== 2'd2) begin bad++; $display("FAIL wb_store_state got=%0d exp=2", state); end
    endtask

    task automatic test_saturate();
        do_reset();
        drive_id(1'b1, OP_BR, 5'd0, 5'd0, 5'd0);
        tick();
        drive_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        repeat (65534) @(posedge clk);
        #1;
        @(negedge clk);
        total++; if (stall_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h exp=fffe", stall_cnt); end
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", stall_cnt); end
        br_resolve = 1'b1;
        tick();
        br_resolve = 1'b0;
        @(negedge clk);
        total++; if ({state, stall_cnt} !== {2'd0, 16'hFFFF})
            begin bad++; $display("FAIL sat_after got=%0d/%h exp=0/ffff", state, stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_branch();
        test_load();
        test_writeback();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
